uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
Shares the single Uart8 transmit channel between NUM_REQ requesters using round-robin arbitration.
Latches the winner's byte and drives txStart/in on Uart8. Holds txStart until Uart8 reports txBusy (Uart8 samples txStart on its slower txClk), then waits for the frame to finish.
Reports completion per requester, and flags a start-handshake timeout.
Sits between firmware-facing producers (command echo, status reporter, debug tap, …) and the Uart8 tx interface. All logic is on the board clock clk.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_BITS, 8, frame width; must match Uart8 DATA_BITS
START_TIMEOUT, 4096, clk cycles allowed between txStart rise and txBusy rise

Ports:
clk  in  1  board clock, same clock that feeds Uart8
reset  in  1  asynchronous, active-high reset
en  in  1  scheduler enable; low blocks new grants only
reqValid  in  NUM_REQ  per-requester "byte pending"
reqData  in  NUM_REQ*DATA_BITS  requester i's byte at bits [i*DATA_BITS +: DATA_BITS]
reqReady  out  NUM_REQ  one-hot, one-cycle pulse: byte accepted
sentValid  out  1  one-cycle pulse: frame finished on the line
sentId  out  $clog2(NUM_REQ)  requester whose frame finished; valid with sentValid
startErr  out  1  one-cycle pulse: start-handshake timeout
txEn  out  1  to Uart8 txEn
txStart  out  1  to Uart8 txStart
txData  out  DATA_BITS  to Uart8 in
txBusy  in  1  from Uart8 txBusy
txDone  in  1  from Uart8 txDone; used for the done/busy consistency check only

Behaviour:
- Reset (async assert, sync-safe deassert):
  - outputs: reqReady=0, sentValid=0, sentId=0, startErr=0, txEn=0, txStart=0, txData=0.
  - internal: state=IDLE, rr pointer=0, timeout counter=0.
- All outputs are registered. txEn follows en with 1-cycle delay.
- FSM states: IDLE, START, SEND.
- IDLE:
  - Entry condition for a grant: en=1, |reqValid=1, and txBusy=0.
  - Winner = first set bit of reqValid, searching from pointer upward and wrapping at NUM_REQ-1 back to 0.
  - Next edge:
    - txData <= winner's byte; requester data is sampled at this edge.
    - reqReady <= onehot(winner) for exactly 1 cycle.
    - grantId <= winner.
    - pointer <= (winner+1) mod NUM_REQ.
    - txStart <= 1; counter <= 0; state -> START.
  - Grant latency: 1 cycle from the reqValid-visible edge to the reqReady pulse.
  - A requester may drop or change reqValid/reqData in the reqReady cycle.
- START:
  - txStart stays 1; txData stays stable.
  - txBusy=1 -> txStart <= 0; state -> SEND.
  - Else, if counter = START_TIMEOUT-1 -> txStart <= 0, startErr pulse, state -> IDLE. No sentValid is issued; the pointer is already advanced, so there is no lockout.
  - Else counter increments. Counter width: $clog2(START_TIMEOUT).
- SEND:
  - Waits for txBusy=0.
  - Then: sentValid pulse, sentId <= grantId, state -> IDLE.
  - IDLE guarantees at least 1 cycle between frames; no new grant while txBusy=1.
- en deasserted mid-frame: the current frame completes normally (START/SEND unaffected); no new grant until en=1.
- Simultaneous events:
  - Several reqValid bits set -> exactly one reqReady bit set.
  - txBusy rise on the same edge the timeout is reached -> txBusy wins (SEND, no startErr).
- Reset mid-frame: txStart drops immediately. Uart8 may still finish its frame, but the scheduler will not grant while txBusy=1 after reset.
- Single-requester fairness: a requester holding reqValid constantly is granted every frame if no one else requests. With k requesters holding valid, each is granted once per k frames.

Decomposition:
- Shared package in inc/Defines.vh:
  - FSM state encoding constants (IDLE, START, SEND, 2-bit).
  - Default START_TIMEOUT constant `UART_START_TIMEOUT.
- One sub-module, rr_arbiter:
  - Parameter NUM_REQ.
  - Inputs: req, pointer. Outputs: grant one-hot, grantIdx, anyReq.
  - Purely combinational and reusable by a future rx-side dispatcher.
- The scheduler holds the FSM, data latch, pointer and counter.

Test Plan:
1. Reset released, reqValid=0001, reqData[7:0]=0x55, Uart8 model raises txBusy 20 cycles after txStart and holds it 160 cycles -> expect:
   - reqReady=0001 one cycle after valid;
   - txData=0x55 and txStart=1 for 20 cycles;
   - sentValid with sentId=0 one cycle after txBusy falls.
2. reqValid=1111 held, bytes 0xA0..0xA3 -> grant/sent order 0,1,2,3,0,1; exactly one reqReady bit per frame; never two frames overlapping.
3. Pointer=2, reqValid=0011 -> grant 0 then 1; pointer wraps correctly.
4. Uart8 model never raises txBusy, START_TIMEOUT=16 -> txStart high exactly 16 cycles, startErr pulse, no sentValid, next requester granted.
5. en dropped during SEND with reqValid=0110 pending -> current frame completes with sentValid; no reqReady until en returns, then requester 1 granted.
6. reset asserted while in START with txStart=1 -> txStart=0 and all outputs at reset values in the same cycle. After release, with txBusy still 1, no grant until txBusy=0.

Source files
------------

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and defaults for the Uart8 transmit scheduler.
package uart_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SEND  = 2'd2
    } sched_state_e;

    localparam int UART_START_TIMEOUT = 4096;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     pointer,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grantIdx,
    output logic               anyReq
);

    always_comb begin
        logic           found;
        int             sum;
        logic [IDW-1:0] idx;
        grant    = '0;
        grantIdx = '0;
        anyReq   = |req;
        found    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = int'(pointer) + i;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            idx = IDW'(sum);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grantIdx   = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of the single Uart8 transmit channel; holds txStart until
// Uart8 acknowledges with txBusy, then waits for the frame to drain.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_BITS     = 8,
    parameter int START_TIMEOUT = UART_START_TIMEOUT,
    localparam int IDW = $clog2(NUM_REQ),
    localparam int CW  = $clog2(START_TIMEOUT)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [NUM_REQ-1:0]           reqValid,
    input  logic [NUM_REQ*DATA_BITS-1:0] reqData,
    output logic [NUM_REQ-1:0]           reqReady,
    output logic                         sentValid,
    output logic [IDW-1:0]               sentId,
    output logic                         startErr,
    output logic                         txEn,
    output logic                         txStart,
    output logic [DATA_BITS-1:0]         txData,
    input  logic                         txBusy,
    input  logic                         txDone
);

    sched_state_e         state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IDW-1:0]       grant_id_q, grant_id_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic                 tx_start_q, tx_start_d;
    logic                 tx_en_q, tx_en_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic                 sent_valid_q, sent_valid_d;
    logic [IDW-1:0]       sent_id_q, sent_id_d;
    logic                 start_err_q, start_err_d;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [IDW-1:0]       arb_idx;
    logic                 arb_any;
    logic [DATA_BITS-1:0] win_data;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req      (reqValid),
        .pointer  (ptr_q),
        .grant    (arb_grant),
        .grantIdx (arb_idx),
        .anyReq   (arb_any)
    );

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                win_data = reqData[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        grant_id_d   = grant_id_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = tx_start_q;
        tx_en_d      = en;
        req_ready_d  = '0;
        sent_valid_d = 1'b0;
        sent_id_d    = sent_id_q;
        start_err_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // txBusy gate also covers a Uart8 frame left running across a reset
                if (en && arb_any && !txBusy) begin
                    tx_data_d   = win_data;
                    req_ready_d = arb_grant;
                    grant_id_d  = arb_idx;
                    ptr_d       = (arb_idx == IDW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    tx_start_d  = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                if (txBusy) begin
                    tx_start_d = 1'b0;
                    state_d    = ST_SEND;
                end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
                    tx_start_d  = 1'b0;
                    start_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SEND: begin
                if (!txBusy) begin
                    sent_valid_d = 1'b1;
                    sent_id_d    = grant_id_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            grant_id_q   <= '0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            tx_en_q      <= 1'b0;
            req_ready_q  <= '0;
            sent_valid_q <= 1'b0;
            sent_id_q    <= '0;
            start_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            grant_id_q   <= grant_id_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            tx_en_q      <= tx_en_d;
            req_ready_q  <= req_ready_d;
            sent_valid_q <= sent_valid_d;
            sent_id_q    <= sent_id_d;
            start_err_q  <= start_err_d;
        end
    end

    assign reqReady  = req_ready_q;
    assign sentValid = sent_valid_q;
    assign sentId    = sent_id_q;
    assign startErr  = start_err_q;
    assign txEn      = tx_en_q;
    assign txStart   = tx_start_q;
    assign txData    = tx_data_q;

    // Uart8 must never report a finished frame while still busy.
    done_busy_consistent: assert property (@(posedge clk) disable iff (reset) !(txDone && txBusy));

endmodule
